// File: rtl/branch_sched_pkg.sv
// Shared backend types: branch op encoding and the branch reservation entry layout.
// Tag and ROB-index fields are sized for the widest supported configuration.
package branch_sched_pkg;

    localparam int BR_MAX_ROB_W  = 8;
    localparam int BR_MAX_PHYS_W = 8;

    typedef enum logic [2:0] {
        BR_BEQ  = 3'd0,
        BR_BNE  = 3'd1,
        BR_BLT  = 3'd2,
        BR_BGE  = 3'd3,
        BR_BLTU = 3'd4,
        BR_BGEU = 3'd5
    } br_ops;

    typedef struct packed {
        logic                     valid;
        br_ops                    op;
        logic [BR_MAX_ROB_W-1:0]  rob_idx;
        logic [BR_MAX_PHYS_W-1:0] ps1;
        logic [BR_MAX_PHYS_W-1:0] ps2;
        logic                     ps1_rdy;
        logic                     ps2_rdy;
        logic [31:0]              rs1_data;
        logic [31:0]              rs2_data;
        logic                     pred_taken;
    } br_sched_entry_t;

endpackage

// File: rtl/branch_sched_if.sv
// Dispatch, CDB wakeup, shared comparator and result handshake of the branch scheduler.
interface branch_sched_if #(
    parameter int ROB_IDX_W = 5,
    parameter int PHYS_W    = 6
) ();
    import branch_sched_pkg::*;

    logic                 dispatch_valid;
    logic                 dispatch_ready;
    br_ops                dispatch_br_op;
    logic [ROB_IDX_W-1:0] dispatch_rob_idx;
    logic                 dispatch_pred_taken;
    logic [PHYS_W-1:0]    dispatch_ps1;
    logic [PHYS_W-1:0]    dispatch_ps2;
    logic                 dispatch_ps1_rdy;
    logic                 dispatch_ps2_rdy;
    logic [31:0]          dispatch_rs1_data;
    logic [31:0]          dispatch_rs2_data;

    logic                 cdb_valid;
    logic [PHYS_W-1:0]    cdb_pd;
    logic [31:0]          cdb_data;

    logic [31:0]          cmp_a;
    logic [31:0]          cmp_b;
    br_ops                cmp_op;
    logic                 cmp_taken;

    logic                 res_valid;
    logic                 res_ready;
    logic [ROB_IDX_W-1:0] res_rob_idx;
    logic                 res_taken;
    logic                 res_mispredict;

    modport master (
        output dispatch_valid, dispatch_br_op, dispatch_rob_idx, dispatch_pred_taken,
               dispatch_ps1, dispatch_ps2, dispatch_ps1_rdy, dispatch_ps2_rdy,
               dispatch_rs1_data, dispatch_rs2_data,
               cdb_valid, cdb_pd, cdb_data, cmp_taken, res_ready,
        input  dispatch_ready, cmp_a, cmp_b, cmp_op,
               res_valid, res_rob_idx, res_taken, res_mispredict
    );

    modport slave (
        input  dispatch_valid, dispatch_br_op, dispatch_rob_idx, dispatch_pred_taken,
               dispatch_ps1, dispatch_ps2, dispatch_ps1_rdy, dispatch_ps2_rdy,
               dispatch_rs1_data, dispatch_rs2_data,
               cdb_valid, cdb_pd, cdb_data, cmp_taken, res_ready,
        output dispatch_ready, cmp_a, cmp_b, cmp_op,
               res_valid, res_rob_idx, res_taken, res_mispredict
    );

endinterface

// File: rtl/branch_sched_age_pick.sv
// br_age_pick: age matrix over the reservation slots and one-hot select of the
// oldest eligible slot. older[i][j] set means slot i was dispatched before slot j.
module br_age_pick #(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [DEPTH-1:0] alloc,
    input  logic [DEPTH-1:0] eligible,
    output logic [DEPTH-1:0] grant
);

    logic [DEPTH-1:0] older [DEPTH];

    // A new slot is younger than everything currently present; stale bits of
    // free slots are harmless because free slots are never eligible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) older[i] <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (alloc[k]) begin
                    for (int j = 0; j < DEPTH; j++) begin
                        if (j != k) begin
                            older[k][j] <= 1'b0;
                            older[j][k] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = eligible[i];
            for (int j = 0; j < DEPTH; j++) begin
                if (j != i && eligible[j] && older[j][i]) grant[i] = 1'b0;
            end
        end
    end

endmodule

// File: rtl/branch_sched.sv
// Branch reservation station: CDB wakeup, oldest-first issue to a shared comparator,
// and a one-deep result register. BR_SCHED_WAKEUP_BYPASS_EN enables same-cycle CDB bypass.
module branch_sched
    import branch_sched_pkg::*;
#(
    parameter int DEPTH     = 4,
    parameter int ROB_IDX_W = 5,
    parameter int PHYS_W    = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    branch_sched_if.slave bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    br_sched_entry_t      ent [DEPTH];
    br_sched_entry_t      new_ent;
    logic [DEPTH-1:0]     valid_vec, hit1, hit2, rdy1_eff, rdy2_eff;
    logic [DEPTH-1:0]     late1, late2;
    logic [DEPTH-1:0]     eligible, grant, free_slot, alloc;
    logic [31:0]          a_eff [DEPTH];
    logic [31:0]          b_eff [DEPTH];
    logic [IDX_W-1:0]     grant_idx;
    logic                 issue, accept, stall;
    logic                 d_hit1, d_hit2, new_late1, new_late2;
    logic                 res_valid_q, res_taken_q, res_mis_q;
    logic [ROB_IDX_W-1:0] res_rob_q;

    assign stall              = res_valid_q & ~bus.res_ready;
    assign bus.dispatch_ready = ~&valid_vec;
    assign accept             = bus.dispatch_valid & ~&valid_vec & ~flush;
    assign d_hit1 = bus.cdb_valid & ~bus.dispatch_ps1_rdy & (bus.cdb_pd == bus.dispatch_ps1);
    assign d_hit2 = bus.cdb_valid & ~bus.dispatch_ps2_rdy & (bus.cdb_pd == bus.dispatch_ps2);
    assign issue  = |grant;

    // Without bypass a stored operand only counts once its ready bit is registered.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            valid_vec[i] = ent[i].valid;
            hit1[i] = bus.cdb_valid & ~ent[i].ps1_rdy & (ent[i].ps1 == BR_MAX_PHYS_W'(bus.cdb_pd));
            hit2[i] = bus.cdb_valid & ~ent[i].ps2_rdy & (ent[i].ps2 == BR_MAX_PHYS_W'(bus.cdb_pd));
`ifdef BR_SCHED_WAKEUP_BYPASS_EN
            rdy1_eff[i] = ent[i].ps1_rdy | hit1[i];
            rdy2_eff[i] = ent[i].ps2_rdy | hit2[i];
            a_eff[i]    = ent[i].ps1_rdy ? ent[i].rs1_data : bus.cdb_data;
            b_eff[i]    = ent[i].ps2_rdy ? ent[i].rs2_data : bus.cdb_data;
`else
            rdy1_eff[i] = ent[i].ps1_rdy;
            rdy2_eff[i] = ent[i].ps2_rdy;
            a_eff[i]    = ent[i].rs1_data;
            b_eff[i]    = ent[i].rs2_data;
`endif
            eligible[i] = ent[i].valid & rdy1_eff[i] & rdy2_eff[i] & ~stall & ~flush;
        end
    end

    always_comb begin
        free_slot = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!ent[i].valid) free_slot = DEPTH'(1) << i;
        end
        alloc = accept ? free_slot : '0;
    end

    // A CDB hit in the dispatch cycle is captured here; without bypass its ready
    // bit lands one cycle later, matching the latency of an ordinary wakeup.
    always_comb begin
        new_ent            = '0;
        new_ent.valid      = 1'b1;
        new_ent.op         = bus.dispatch_br_op;
        new_ent.rob_idx    = BR_MAX_ROB_W'(bus.dispatch_rob_idx);
        new_ent.ps1        = BR_MAX_PHYS_W'(bus.dispatch_ps1);
        new_ent.ps2        = BR_MAX_PHYS_W'(bus.dispatch_ps2);
        new_ent.rs1_data   = d_hit1 ? bus.cdb_data : bus.dispatch_rs1_data;
        new_ent.rs2_data   = d_hit2 ? bus.cdb_data : bus.dispatch_rs2_data;
        new_ent.pred_taken = bus.dispatch_pred_taken;
`ifdef BR_SCHED_WAKEUP_BYPASS_EN
        new_ent.ps1_rdy    = bus.dispatch_ps1_rdy | d_hit1;
        new_ent.ps2_rdy    = bus.dispatch_ps2_rdy | d_hit2;
        new_late1          = 1'b0;
        new_late2          = 1'b0;
`else
        new_ent.ps1_rdy    = bus.dispatch_ps1_rdy;
        new_ent.ps2_rdy    = bus.dispatch_ps2_rdy;
        new_late1          = d_hit1;
        new_late2          = d_hit2;
`endif
    end

    br_age_pick #(.DEPTH(DEPTH)) u_age_pick (
        .clk      (clk),
        .rst_n    (rst_n),
        .alloc    (alloc),
        .eligible (eligible),
        .grant    (grant)
    );

    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) grant_idx = IDX_W'(i);
        end
        bus.cmp_a  = '0;
        bus.cmp_b  = '0;
        bus.cmp_op = BR_BEQ;
        if (issue) begin
            bus.cmp_a  = a_eff[grant_idx];
            bus.cmp_b  = b_eff[grant_idx];
            bus.cmp_op = ent[grant_idx].op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
            late1 <= '0;
            late2 <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
            late1 <= '0;
            late2 <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (alloc[i]) begin
                    ent[i]   <= new_ent;
                    late1[i] <= new_late1;
                    late2[i] <= new_late2;
                end else if (ent[i].valid) begin
                    if (grant[i]) ent[i].valid <= 1'b0;
                    if (late1[i]) begin
                        ent[i].ps1_rdy <= 1'b1;
                        late1[i]       <= 1'b0;
                    end else if (hit1[i]) begin
                        ent[i].ps1_rdy  <= 1'b1;
                        ent[i].rs1_data <= bus.cdb_data;
                    end
                    if (late2[i]) begin
                        ent[i].ps2_rdy <= 1'b1;
                        late2[i]       <= 1'b0;
                    end else if (hit2[i]) begin
                        ent[i].ps2_rdy  <= 1'b1;
                        ent[i].rs2_data <= bus.cdb_data;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_rob_q   <= '0;
            res_taken_q <= 1'b0;
            res_mis_q   <= 1'b0;
        end else if (flush) begin
            res_valid_q <= 1'b0;
        end else if (issue) begin
            res_valid_q <= 1'b1;
            res_rob_q   <= ent[grant_idx].rob_idx[ROB_IDX_W-1:0];
            res_taken_q <= bus.cmp_taken;
            res_mis_q   <= bus.cmp_taken ^ ent[grant_idx].pred_taken;
        end else if (bus.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    assign bus.res_valid      = res_valid_q;
    assign bus.res_rob_idx    = res_rob_q;
    assign bus.res_taken      = res_taken_q;
    assign bus.res_mispredict = res_mis_q;

endmodule

// File: tb/tb_branch_sched.sv
// Directed bench for branch_sched: results are scoreboarded in expected issue order,
// timing and idle behaviour are checked directly against hand-computed values.
module tb_branch_sched;
    import branch_sched_pkg::*;

`ifdef BR_SCHED_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] rob;
        logic       taken;
        logic       mis;
    } exp_t;

    logic clk;
    logic rst_n;
    logic flush;
    int   total;
    int   bad;
    exp_t sb [$];
    exp_t mon_exp;
    exp_t mon_act;

    branch_sched_if #(.ROB_IDX_W(5), .PHYS_W(6)) bus ();

    branch_sched #(.DEPTH(4), .ROB_IDX_W(5), .PHYS_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic cmp_model(br_ops op, logic [31:0] a, logic [31:0] b);
        case (op)
            BR_BEQ:  return a == b;
            BR_BNE:  return a != b;
            BR_BLT:  return $signed(a) <  $signed(b);
            BR_BGE:  return $signed(a) >= $signed(b);
            BR_BLTU: return a <  b;
            BR_BGEU: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    assign bus.cmp_taken = cmp_model(bus.cmp_op, bus.cmp_a, bus.cmp_b);

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic valid, input br_ops op, input logic [4:0] rob,
                                 input logic [5:0] ps1, input logic ps1_rdy, input logic [31:0] rs1,
                                 input logic [5:0] ps2, input logic ps2_rdy, input logic [31:0] rs2,
                                 input logic pred);
        bus.dispatch_valid      = valid;
        bus.dispatch_br_op      = op;
        bus.dispatch_rob_idx    = rob;
        bus.dispatch_ps1        = ps1;
        bus.dispatch_ps1_rdy    = ps1_rdy;
        bus.dispatch_rs1_data   = rs1;
        bus.dispatch_ps2        = ps2;
        bus.dispatch_ps2_rdy    = ps2_rdy;
        bus.dispatch_rs2_data   = rs2;
        bus.dispatch_pred_taken = pred;
    endtask

    task automatic setCdb(input logic valid, input logic [5:0] pd, input logic [31:0] data);
        bus.cdb_valid = valid;
        bus.cdb_pd    = pd;
        bus.cdb_data  = data;
    endtask

    task automatic idle();
        applyStimulus(1'b0, BR_BEQ, 5'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0, 1'b0);
        setCdb(1'b0, 6'd0, 32'd0);
    endtask

    task automatic expectResult(input logic [4:0] rob, input logic taken, input logic mis);
        exp_t e;
        e.rob   = rob;
        e.taken = taken;
        e.mis   = mis;
        sb.push_back(e);
    endtask

    // Monitor: every accepted result is matched against the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && bus.res_valid && bus.res_ready) begin
            mon_act = {bus.res_rob_idx, bus.res_taken, bus.res_mispredict};
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("[TB] FAIL unexpected_result: got rob=%0d taken=%0d mis=%0d expected none",
                         bus.res_rob_idx, bus.res_taken, bus.res_mispredict);
            end else begin
                mon_exp = sb.pop_front();
                if (mon_act !== mon_exp) begin
                    bad++;
                    $display("[TB] FAIL result: got rob=%0d taken=%0d mis=%0d expected rob=%0d taken=%0d mis=%0d",
                             mon_act.rob, mon_act.taken, mon_act.mis, mon_exp.rob, mon_exp.taken, mon_exp.mis);
                end
            end
        end
    end

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        flush = 1'b0;
        bus.res_ready = 1'b1;
        idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        #2;
        checkOutput("reset_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("reset_dispatch_ready", 32'(bus.dispatch_ready), 32'd1);
        checkOutput("reset_cmp_op", 32'(bus.cmp_op), 32'(BR_BEQ));
        checkOutput("reset_cmp_a", bus.cmp_a, 32'd0);

        // bge -1 vs 1 is not taken; bgeu on the same bits is taken.
        step();
        $display("[TB] signed vs unsigned compare");
        applyStimulus(1'b1, BR_BGE, 5'd1, 6'd1, 1'b1, 32'hFFFF_FFFF, 6'd2, 1'b1, 32'd1, 1'b0);
        expectResult(5'd1, 1'b0, 1'b0);
        step();
        idle();
        #2;
        checkOutput("bge_issue_op", 32'(bus.cmp_op), 32'(BR_BGE));
        checkOutput("bge_issue_a", bus.cmp_a, 32'hFFFF_FFFF);
        checkOutput("bge_issue_b", bus.cmp_b, 32'd1);
        step();
        #2;
        checkOutput("bge_res_valid", 32'(bus.res_valid), 32'd1);
        checkOutput("bge_res_taken", 32'(bus.res_taken), 32'd0);
        step();
        applyStimulus(1'b1, BR_BGEU, 5'd2, 6'd1, 1'b1, 32'hFFFF_FFFF, 6'd2, 1'b1, 32'd1, 1'b0);
        expectResult(5'd2, 1'b1, 1'b1);
        step();
        idle();
        #2;
        checkOutput("bgeu_issue_op", 32'(bus.cmp_op), 32'(BR_BGEU));
        step();
        #2;
        checkOutput("bgeu_res_mis", 32'(bus.res_mispredict), 32'd1);

        // Fill all slots waiting on ps1, then wake out of order.
        $display("[TB] fill and out-of-order wakeup");
        step();
        applyStimulus(1'b1, BR_BEQ, 5'd10, 6'd3, 1'b0, 32'hDEAD, 6'd0, 1'b1, 32'd7, 1'b1);
        step();
        applyStimulus(1'b1, BR_BEQ, 5'd11, 6'd1, 1'b0, 32'hDEAD, 6'd0, 1'b1, 32'd7, 1'b1);
        step();
        applyStimulus(1'b1, BR_BEQ, 5'd12, 6'd3, 1'b0, 32'hDEAD, 6'd0, 1'b1, 32'd7, 1'b1);
        step();
        applyStimulus(1'b1, BR_BEQ, 5'd13, 6'd5, 1'b0, 32'hDEAD, 6'd0, 1'b1, 32'd7, 1'b1);
        step();
        applyStimulus(1'b1, BR_BEQ, 5'd14, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1, 1'b1);
        #2;
        checkOutput("full_dispatch_ready", 32'(bus.dispatch_ready), 32'd0);
        checkOutput("full_no_issue", 32'(bus.cmp_op), 32'(BR_BEQ));
        checkOutput("full_cmp_b", bus.cmp_b, 32'd0);
        expectResult(5'd10, 1'b1, 1'b0);
        expectResult(5'd11, 1'b0, 1'b1);
        expectResult(5'd12, 1'b1, 1'b0);
        step();
        idle();
        setCdb(1'b1, 6'd3, 32'd7);
        step();
        setCdb(1'b1, 6'd1, 32'd8);
        step();
        setCdb(1'b0, 6'd0, 32'd0);
        repeat (4) step();
        #2;
        checkOutput("drain_dispatch_ready", 32'(bus.dispatch_ready), 32'd1);
        expectResult(5'd13, 1'b1, 1'b0);
        step();
        setCdb(1'b1, 6'd5, 32'd7);
        step();
        setCdb(1'b0, 6'd0, 32'd0);
        repeat (4) step();

        // Stall the result register with two ready branches queued.
        $display("[TB] result backpressure");
        bus.res_ready = 1'b0;
        applyStimulus(1'b1, BR_BEQ, 5'd20, 6'd0, 1'b1, 32'd5, 6'd0, 1'b1, 32'd5, 1'b0);
        expectResult(5'd20, 1'b1, 1'b1);
        step();
        applyStimulus(1'b1, BR_BNE, 5'd21, 6'd0, 1'b1, 32'd5, 6'd0, 1'b1, 32'd5, 1'b0);
        expectResult(5'd21, 1'b0, 1'b0);
        step();
        idle();
        for (int k = 0; k < 5; k++) begin
            #2;
            checkOutput("stall_res_valid", 32'(bus.res_valid), 32'd1);
            checkOutput("stall_res_rob", 32'(bus.res_rob_idx), 32'd20);
            checkOutput("stall_res_taken", 32'(bus.res_taken), 32'd1);
            checkOutput("stall_cmp_op", 32'(bus.cmp_op), 32'(BR_BEQ));
            checkOutput("stall_cmp_a", bus.cmp_a, 32'd0);
            step();
        end
        bus.res_ready = 1'b1;
        #2;
        checkOutput("release_issue_op", 32'(bus.cmp_op), 32'(BR_BNE));
        step();
        #2;
        checkOutput("b2b_res_valid", 32'(bus.res_valid), 32'd1);
        checkOutput("b2b_res_rob", 32'(bus.res_rob_idx), 32'd21);
        step();
        #2;
        checkOutput("b2b_drained", 32'(bus.res_valid), 32'd0);

        // CDB hit in the dispatch cycle.
        $display("[TB] dispatch-cycle wakeup");
        step();
        applyStimulus(1'b1, BR_BNE, 5'd30, 6'd4, 1'b1, 32'd1, 6'd9, 1'b0, 32'h123, 1'b1);
        setCdb(1'b1, 6'd9, 32'd2);
        expectResult(5'd30, 1'b1, 1'b0);
        step();
        idle();
        #2;
        checkOutput("wake_t1_op", 32'(bus.cmp_op), BYP ? 32'(BR_BNE) : 32'(BR_BEQ));
        checkOutput("wake_t1_b", bus.cmp_b, BYP ? 32'd2 : 32'd0);
        step();
        #2;
        checkOutput("wake_t2_op", 32'(bus.cmp_op), BYP ? 32'(BR_BEQ) : 32'(BR_BNE));
        checkOutput("wake_t2_b", bus.cmp_b, BYP ? 32'd0 : 32'd2);
        repeat (3) step();

        // Flush with a held result and three waiting entries.
        $display("[TB] flush");
        bus.res_ready = 1'b0;
        applyStimulus(1'b1, BR_BEQ, 5'd40, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 1'b0);
        step();
        applyStimulus(1'b1, BR_BLTU, 5'd41, 6'd12, 1'b0, 32'd0, 6'd0, 1'b1, 32'd9, 1'b0);
        step();
        applyStimulus(1'b1, BR_BLTU, 5'd42, 6'd12, 1'b0, 32'd0, 6'd0, 1'b1, 32'd9, 1'b0);
        step();
        applyStimulus(1'b1, BR_BLTU, 5'd43, 6'd12, 1'b0, 32'd0, 6'd0, 1'b1, 32'd9, 1'b0);
        step();
        flush = 1'b1;
        applyStimulus(1'b1, BR_BEQ, 5'd44, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 1'b0);
        #2;
        checkOutput("preflush_res_valid", 32'(bus.res_valid), 32'd1);
        step();
        flush = 1'b0;
        idle();
        bus.res_ready = 1'b1;
        #2;
        checkOutput("flush_res_valid", 32'(bus.res_valid), 32'd0);
        checkOutput("flush_dispatch_ready", 32'(bus.dispatch_ready), 32'd1);
        checkOutput("flush_cmp_op", 32'(bus.cmp_op), 32'(BR_BEQ));
        step();
        setCdb(1'b1, 6'd12, 32'h55);
        #2;
        checkOutput("flush_cdb_t0_op", 32'(bus.cmp_op), 32'(BR_BEQ));
        step();
        setCdb(1'b0, 6'd0, 32'd0);
        #2;
        checkOutput("flush_cdb_t1_op", 32'(bus.cmp_op), 32'(BR_BEQ));
        repeat (4) step();

        // Reset asserted during an issue cycle.
        $display("[TB] reset mid-issue");
        applyStimulus(1'b1, BR_BLTU, 5'd50, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2, 1'b1);
        step();
        idle();
        #2;
        checkOutput("preReset_issue_op", 32'(bus.cmp_op), 32'(BR_BLTU));
        rst_n = 1'b0;
        #1;
        checkOutput("rst_cmp_op", 32'(bus.cmp_op), 32'(BR_BEQ));
        checkOutput("rst_cmp_a", bus.cmp_a, 32'd0);
        checkOutput("rst_res_valid", 32'(bus.res_valid), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #2;
            checkOutput("postReset_res_valid", 32'(bus.res_valid), 32'd0);
            checkOutput("postReset_dispatch_ready", 32'(bus.dispatch_ready), 32'd1);
            step();
        end

        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
